fft2_cmul: RTL
==============

# fft2_cmul

Pointwise complex multiplier between the forward fft2 stage and the inverse fft2 stage of the convolution datapath. On `start` it walks a 2^(log2w+log2h)-element spectrum, reads image spectrum A and kernel spectrum B at the same linear address, multiplies them in signed fixed point, and writes the product to the output buffer that the inverse fft2 pass consumes. Memory ports use the same request/acknowledge address style as fft2.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each real or imaginary word, signed two's complement.
- FFT_SIZE, 16, maximum matrix side; power of two.
- FIXED_POINT_WIDTH, 16, number of fractional bits in operands and results.

Ports. Localparams: AW = $clog2(FFT_SIZE*FFT_SIZE); LW = $clog2($clog2(FFT_SIZE)+1).
- pclk in 1: the single clock.
- presetn in 1: reset. Asynchronous, active-low.
- start in 1: one-cycle pulse; sampled only while ready=1.
- ready out 1: high when idle; low while an operation runs.
- log2w in LW: log2 of matrix width; latched on accepted start.
- log2h in LW: log2 of matrix height; latched on accepted start.
- data_i_addr_o out AW: linear read address, shared by A and B.
- data_rd_o out 1: read request; held until acknowledged.
- data_rd_i in 1: read acknowledge; A/B data valid in the same cycle.
- aRE_i, aIM_i in DATA_WIDTH each: A operand.
- bRE_i, bIM_i in DATA_WIDTH each: B operand.
- data_o_addr_o out AW: write address.
- dataRE_o, dataIM_o out DATA_WIDTH each: product.
- data_wr_o out 1: write request; address and data held stable until acknowledged.
- data_wr_i in 1: write acknowledge.

## Operation
- FSM states: IDLE, READ, MUL, WRITE.
- IDLE: ready=1.
  - On start=1: latch log2w/log2h, set idx=0, set last = 2^(log2w+log2h)-1, go to READ. ready drops the next cycle.
- READ: data_rd_o=1, data_i_addr_o=idx.
  - On data_rd_i=1: register the four operands and go to MUL.
- MUL: one cycle. Register, computed at full precision (2*DATA_WIDTH+1 bits):
  - re = (aRE*bRE − aIM*bIM) >>> FIXED_POINT_WIDTH
  - im = (aRE*bIM + aIM*bRE) >>> FIXED_POINT_WIDTH
  - The arithmetic shift floors toward −infinity. Narrowing to DATA_WIDTH follows the Configuration section. Go to WRITE.
- WRITE: data_wr_o=1, data_o_addr_o=idx, dataRE_o/dataIM_o=re/im.
  - On data_wr_i=1 with idx==last: go to IDLE; ready=1 the next cycle.
  - On data_wr_i=1 otherwise: idx++, go to READ.
- log2w+log2h must be ≤ 2·log2(FFT_SIZE). Larger values are illegal and the behaviour is unspecified.
- log2w=log2h=0 processes exactly one element.

## Timing
- Reset values:
  - ready=1; all other outputs 0; FSM=IDLE; idx=0.
  - Reset asserted mid-operation aborts immediately. No further rd/wr requests are issued after deassertion.
- Per element: 1 cycle READ minimum (more if ack is delayed) + 1 cycle MUL + 1 cycle WRITE minimum. With zero-wait acks this is 3 cycles/element.
- Total minimum from accepted start to ready=1: 3·N + 1 cycles.
- data_rd_o and data_wr_o are never asserted in the same cycle.
- A request stays asserted and its address and data stay stable until acknowledged.
- Acks arriving while the matching request is low are ignored.
- start while ready=0 is ignored. start in the same cycle ready returns to 1 is accepted.

## Configuration
- FFT2_CMUL_SAT_EN defined: each narrowed result clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] when it is out of range.
- FFT2_CMUL_SAT_EN undefined: the low DATA_WIDTH bits are kept (wrap-around). This saves the comparators.

## Test plan
- Single element (log2w=log2h=0), A=(1+2j), B=(3+4j) in Q16 (0x00010000, 0x00020000 / 0x00030000, 0x00040000) -> one write to addr 0 of RE=0xFFFB0000 (−5.0), IM=0x000A0000 (10.0); ready high 4 cycles after start.
- 4x4 (log2w=log2h=2), B=1.0+0j everywhere, A[i]=i·0x10000 + j·(−i·0x10000) -> 16 writes, addresses 0..15 in order, output equal to A; 49 cycles with zero-wait acks.
- Overflow: aRE=bRE=0x7FFF0000, all imaginary parts 0 -> with FFT2_CMUL_SAT_EN, RE=0x7FFFFFFF; without it, RE=0x00010000; IM=0 in both builds.
- Handshake stalls: hold data_rd_i low for 5 cycles and data_wr_i low for 3 cycles -> addresses and data stay stable throughout; no duplicate or skipped addresses; acks given outside a request have no effect.
- start pulsed during a 2x2 run -> ignored, exactly 4 writes occur. Then presetn driven low mid-WRITE -> ready=1, data_wr_o=0 asynchronously; a new start runs from address 0.

Source files
------------

// File: rtl/fft2_cmul.sv
// fft2_cmul
// Pointwise complex multiplier sitting between the forward and inverse fft2
// passes of the convolution datapath. After an accepted start it walks every
// element of a 2^(log2w+log2h) spectrum: reads A and B at the same linear
// address, forms A*B in signed fixed point, and writes the product out.
//
// Build option:
//   FFT2_CMUL_SAT_EN  defined   -> narrowed results clamp to the signed range
//                     undefined -> narrowed results keep the low DATA_WIDTH
//                                  bits (wrap-around)
//
// Ports:
//   pclk, presetn           clock, async active-low reset
//   start, ready            start pulse (sampled while ready), idle flag
//   log2w, log2h            matrix shape, captured on accepted start
//   data_i_addr_o           read address shared by A and B
//   data_rd_o / data_rd_i   read request / acknowledge (operands valid on ack)
//   aRE_i, aIM_i            A operand
//   bRE_i, bIM_i            B operand
//   data_o_addr_o           write address
//   dataRE_o, dataIM_o      product
//   data_wr_o / data_wr_i   write request / acknowledge
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready=1, waiting for start
// READ  | read request for element idx, hold until acknowledged
// MUL   | one cycle: form and narrow the complex product
// WRITE | write request for element idx, hold until acknowledged

module fft2_cmul #(
    parameter int DATA_WIDTH        = 32,
    parameter int FFT_SIZE          = 16,
    parameter int FIXED_POINT_WIDTH = 16,
    localparam int AW = $clog2(FFT_SIZE * FFT_SIZE),
    localparam int LW = $clog2($clog2(FFT_SIZE) + 1)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  start,
    output logic                  ready,
    input  logic [LW-1:0]         log2w,
    input  logic [LW-1:0]         log2h,
    output logic [AW-1:0]         data_i_addr_o,
    output logic                  data_rd_o,
    input  logic                  data_rd_i,
    input  logic [DATA_WIDTH-1:0] aRE_i,
    input  logic [DATA_WIDTH-1:0] aIM_i,
    input  logic [DATA_WIDTH-1:0] bRE_i,
    input  logic [DATA_WIDTH-1:0] bIM_i,
    output logic [AW-1:0]         data_o_addr_o,
    output logic [DATA_WIDTH-1:0] dataRE_o,
    output logic [DATA_WIDTH-1:0] dataIM_o,
    output logic                  data_wr_o,
    input  logic                  data_wr_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_MUL   = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = 2 * DATA_WIDTH + 1;

    logic [1:0]                   state;
    logic [AW-1:0]                idx;
    logic [AW-1:0]                last;
    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic [DATA_WIDTH-1:0]        res_re, res_im;

    // Shape sum needs one extra bit: two maximal log2 values overflow LW.
    logic [LW:0] shamt;
    assign shamt = {1'b0, log2w} + {1'b0, log2h};

    // Full-precision products; the extra sum bit keeps the add/subtract exact.
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic [SUM_W-1:0]         sum_re, sum_im;
    logic signed [SUM_W-1:0]  sh_re, sh_im;
    logic [DATA_WIDTH-1:0]    nar_re, nar_im;

    assign p_rr = PROD_W'(a_re) * PROD_W'(b_re);
    assign p_ii = PROD_W'(a_im) * PROD_W'(b_im);
    assign p_ri = PROD_W'(a_re) * PROD_W'(b_im);
    assign p_ir = PROD_W'(a_im) * PROD_W'(b_re);

    assign sum_re = {p_rr[PROD_W-1], p_rr} - {p_ii[PROD_W-1], p_ii};
    assign sum_im = {p_ri[PROD_W-1], p_ri} + {p_ir[PROD_W-1], p_ir};

    // Arithmetic shift floors toward -infinity.
    assign sh_re = $signed(sum_re) >>> FIXED_POINT_WIDTH;
    assign sh_im = $signed(sum_im) >>> FIXED_POINT_WIDTH;

`ifdef FFT2_CMUL_SAT_EN
    localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // In range when every bit above the narrowed sign bit matches the sign.
    logic ovf_re, ovf_im;
    assign ovf_re = (sh_re[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){sh_re[SUM_W-1]}});
    assign ovf_im = (sh_im[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){sh_im[SUM_W-1]}});

    assign nar_re = ovf_re ? (sh_re[SUM_W-1] ? MIN_V : MAX_V) : sh_re[DATA_WIDTH-1:0];
    assign nar_im = ovf_im ? (sh_im[SUM_W-1] ? MIN_V : MAX_V) : sh_im[DATA_WIDTH-1:0];
`else
    assign nar_re = sh_re[DATA_WIDTH-1:0];
    assign nar_im = sh_im[DATA_WIDTH-1:0];

    // Upper bits are intentionally dropped in the wrap-around build.
    logic unused_hi;
    assign unused_hi = ^{sh_re[SUM_W-1:DATA_WIDTH], sh_im[SUM_W-1:DATA_WIDTH]};
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state  <= ST_IDLE;
            idx    <= '0;
            last   <= '0;
            a_re   <= '0;
            a_im   <= '0;
            b_re   <= '0;
            b_im   <= '0;
            res_re <= '0;
            res_im <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        // 2^shamt - 1 without needing a wider intermediate.
                        last  <= ~({AW{1'b1}} << shamt);
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (data_rd_i) begin
                        a_re  <= aRE_i;
                        a_im  <= aIM_i;
                        b_re  <= bRE_i;
                        b_im  <= bIM_i;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    res_re <= nar_re;
                    res_im <= nar_im;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (data_wr_i) begin
                        if (idx == last) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready         = (state == ST_IDLE);
    assign data_rd_o     = (state == ST_READ);
    assign data_wr_o     = (state == ST_WRITE);
    assign data_i_addr_o = idx;
    assign data_o_addr_o = idx;
    assign dataRE_o      = res_re;
    assign dataIM_o      = res_im;

endmodule
